// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU multi-cycle units (MUL/DIV).
//   WORD_W        operand width
//   mul_state_t   multiplier FSM states
//   booth_op_t    recoded Booth operation per step
//   MUL_*         build-dependent multiplier geometry; selected by the
//                 BOOTH_MUL_RADIX4_EN macro (radix-4 when defined, radix-2 otherwise)
package alu_pkg;
  localparam int WORD_W      = 32;
  localparam int MUL_ITER_R2 = 32;
  localparam int MUL_ITER_R4 = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
  typedef enum logic [2:0] {NOP, ADD_M, SUB_M, ADD_2M, SUB_2M} booth_op_t;

`ifdef BOOTH_MUL_RADIX4_EN
  localparam int MUL_ITER  = MUL_ITER_R4;
  localparam int MUL_SHIFT = 2;
  localparam int MUL_ACC_W = WORD_W + 2;  // room for +/-2M
  localparam int MUL_RCD_W = 3;
`else
  localparam int MUL_ITER  = MUL_ITER_R2;
  localparam int MUL_SHIFT = 1;
  localparam int MUL_ACC_W = WORD_W + 1;  // -(-2^31) must not overflow
  localparam int MUL_RCD_W = 2;
`endif

  // Sized for the larger radix-2 count so both builds share one counter width.
  localparam int MUL_CNT_W = $clog2(MUL_ITER_R2);
endpackage

// File: rtl/booth_recode.sv
// booth_recode: combinational Booth recoder.
//   bits_i  recoder window: {Q[0],Q[-1]} (radix-2) or {Q[1],Q[0],Q[-1]}
//           (radix-4, when BOOTH_MUL_RADIX4_EN is defined)
//   op_o    operation applied to the accumulator this step
module booth_recode
  import alu_pkg::*;
(
  input  logic [MUL_RCD_W-1:0] bits_i,
  output booth_op_t            op_o
);
  always_comb begin
    op_o = NOP;
`ifdef BOOTH_MUL_RADIX4_EN
    case (bits_i)
      3'b001, 3'b010: op_o = ADD_M;
      3'b011:         op_o = ADD_2M;
      3'b100:         op_o = SUB_2M;
      3'b101, 3'b110: op_o = SUB_M;
      default:        op_o = NOP;
    endcase
`else
    case (bits_i)
      2'b01:   op_o = ADD_M;
      2'b10:   op_o = SUB_M;
      default: op_o = NOP;
    endcase
`endif
  end
endmodule

// File: rtl/booth_mul.sv
// booth_mul: sequential signed WIDTH x WIDTH Booth multiplier, start/done handshake.
//   clk, reset     single clock, synchronous active-high reset
//   start          operand strobe, sampled only in IDLE
//   Multiplicand   signed M, latched on accept
//   Multiplier     signed Q, latched on accept
//   Z              {HI,LO} product, updated only when DONE is entered
//   busy           high while stepping
//   done           one-cycle pulse, Z valid in the same cycle
// BOOTH_MUL_RADIX4_EN selects radix-4 recoding (16 steps) instead of radix-2 (32 steps).
module booth_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Z,
  output logic               busy,
  output logic               done
);
  localparam int ACC_W = WIDTH + (MUL_ACC_W - WORD_W);

  mul_state_t           state_q;
  logic [ACC_W-1:0]     a_q;
  logic [WIDTH-1:0]     q_q, m_q;
  logic                 qm1_q;
  logic [MUL_CNT_W-1:0] cnt_q;
  logic                 last_q;   // final step applied; next BUSY edge publishes Z
  logic [2*WIDTH-1:0]   z_q;
  logic                 busy_q, done_q;

  booth_op_t            op;
  logic [ACC_W-1:0]     m_ext, m_x2, sum_d, a_d;
  logic [WIDTH-1:0]     q_d;
  logic                 qm1_d;
  logic signed [ACC_W+WIDTH:0] cat_d, sh_d;

`ifdef BOOTH_MUL_RADIX4_EN
  booth_recode u_rcd (.bits_i({q_q[1:0], qm1_q}), .op_o(op));
`else
  booth_recode u_rcd (.bits_i({q_q[0], qm1_q}), .op_o(op));
`endif

  assign m_ext = {{(ACC_W-WIDTH){m_q[WIDTH-1]}}, m_q};
  assign m_x2  = {m_ext[ACC_W-2:0], 1'b0};

  // One Booth step: accumulate, then arithmetic shift of {A,Q,Q[-1]}.
  always_comb begin
    sum_d = a_q;
    case (op)
      ADD_M:   sum_d = a_q + m_ext;
      SUB_M:   sum_d = a_q - m_ext;
      ADD_2M:  sum_d = a_q + m_x2;
      SUB_2M:  sum_d = a_q - m_x2;
      default: sum_d = a_q;
    endcase
    cat_d = {sum_d, q_q, qm1_q};
    sh_d  = cat_d >>> MUL_SHIFT;
    a_d   = sh_d[ACC_W+WIDTH:WIDTH+1];
    q_d   = sh_d[WIDTH:1];
    qm1_d = sh_d[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= Multiplicand;
            q_q     <= Multiplier;
            a_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= MUL_CNT_W'(MUL_ITER - 1);
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (last_q) begin
            z_q     <= {a_q[WIDTH-1:0], q_q};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
            if (cnt_q == '0) last_q <= 1'b1;
            else             cnt_q  <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // start is deliberately ignored here; a new op needs a fresh IDLE cycle
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Z    = z_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
